// File: rtl/exhaustive_seq_pkg.sv
// Shared types and helpers for the exhaustive pattern sequencer and its MISR.
package exhaustive_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  localparam logic [15:0] MISR_POLY  = 16'h1021;
  localparam int unsigned MISR_MAX_W = 32;
  localparam int unsigned SETTLE_CNT_W = 4;

  // One MISR step for any width up to MISR_MAX_W: shift left, fold the
  // polynomial in when the outgoing MSB is set, inject bit_in at the LSB.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic                  bit_in,
    input int unsigned           width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] nxt;
    mask = (MISR_MAX_W'(1) << width) - MISR_MAX_W'(1);
    nxt  = sig << 1;
    if (sig[width-1]) begin
      nxt = nxt ^ MISR_MAX_W'(MISR_POLY);
    end
    nxt = nxt ^ MISR_MAX_W'(bit_in);
    return nxt & mask;
  endfunction

endpackage

// File: rtl/seq_misr.sv
// Signature register: multiple-input shift register compacting a 1-bit stream.
module seq_misr
  import exhaustive_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  // Next signature: clear wins over a compaction step.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = WIDTH'(misr_step(MISR_MAX_W'(sig_q), bit_in, WIDTH));
    end
  end

  // Signature register with asynchronous active-low reset.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/exhaustive_pattern_sequencer.sv
// Exhaustive stimulus sequencer: sweeps every N_WIDTH-bit pattern, waits a
// settle time, samples the 1-bit response into a bit vector and a MISR.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold
// SETTLE | pattern on N, counting settle cycles
// SAMPLE | capture dut_out on the exit edge, then advance or finish
// DONE   | sweep complete; results frozen until next start
module exhaustive_pattern_sequencer
  import exhaustive_seq_pkg::*;
#(
  parameter int unsigned N_WIDTH       = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned SIG_WIDTH     = 16
) (
  input  logic                     CK,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  output logic [0:N_WIDTH-1]       N,
  input  logic                     dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     resp_valid,
  output logic [N_WIDTH-1:0]       resp_index,
  output logic [(2**N_WIDTH)-1:0]  resp_bits,
  output logic [SIG_WIDTH-1:0]     signature
);

  localparam int unsigned NPAT = 2**N_WIDTH;
  localparam logic [N_WIDTH-1:0]      PAT_LAST   = N_WIDTH'(NPAT - 1);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_END = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  seq_state_e              state_q, state_d;
  logic [N_WIDTH-1:0]      pat_q, pat_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [N_WIDTH-1:0]      resp_index_q, resp_index_d;
  logic [NPAT-1:0]         resp_bits_q, resp_bits_d;
  logic                    misr_clr;
  logic                    misr_en;

  // Next-state and datapath control; abort overrides every transition.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_index_d = resp_index_q;
    resp_bits_d  = resp_bits_q;
    misr_clr     = 1'b0;
    misr_en      = 1'b0;

    if (abort) begin
      state_d = IDLE;
      pat_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d     = SETTLE;
            pat_d       = '0;
            cnt_d       = '0;
            resp_bits_d = '0;
            misr_clr    = 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_END) begin
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SAMPLE: begin
          resp_bits_d[pat_q] = dut_out;
          misr_en            = 1'b1;
          resp_valid_d       = 1'b1;
          resp_index_d       = pat_q;
          if (pat_q == PAT_LAST) begin
            state_d = DONE;
          end else begin
            state_d = SETTLE;
            pat_d   = pat_q + 1'b1;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Control and capture registers.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pat_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_index_q <= '0;
      resp_bits_q  <= '0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_index_q <= resp_index_d;
      resp_bits_q  <= resp_bits_d;
    end
  end

  seq_misr #(
    .WIDTH (SIG_WIDTH)
  ) u_misr (
    .CK     (CK),
    .reset  (reset),
    .clr    (misr_clr),
    .en     (misr_en),
    .bit_in (dut_out),
    .sig    (signature)
  );

  // N is MSB-first ([0] is the MSB), so a plain packed copy keeps ordering.
  assign N          = pat_q;
  assign busy       = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done       = (state_q == DONE);
  assign resp_valid = resp_valid_q;
  assign resp_index = resp_index_q;
  assign resp_bits  = resp_bits_q;

endmodule

// File: tb/tb_exhaustive_pattern_sequencer.sv
module tb_exhaustive_pattern_sequencer;

  localparam int NW   = 4;
  localparam int SC   = 1;
  localparam int NPAT = 16;
  localparam int PER  = SC + 1;
  localparam int SWEEP = NPAT * PER;

  logic        CK = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [0:NW-1] N;
  logic        dut_out;
  logic        busy, done, resp_valid;
  logic [NW-1:0]   resp_index;
  logic [NPAT-1:0] resp_bits;
  logic [15:0]     signature;

  logic [15:0] truth = 16'h0;
  logic [NW-1:0] n_val;
  int n_checks = 0;
  int n_fail   = 0;

  assign n_val   = N;
  assign dut_out = truth[n_val];

  always #5 CK = ~CK;

  exhaustive_pattern_sequencer #(
    .N_WIDTH(NW), .SETTLE_CYCLES(SC), .SIG_WIDTH(16)
  ) dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .N(N),
    .dut_out(dut_out), .busy(busy), .done(done), .resp_valid(resp_valid),
    .resp_index(resp_index), .resp_bits(resp_bits), .signature(signature)
  );

  // Reference: compacting the first n responses in pattern order.
  function automatic logic [15:0] model_sig(input logic [15:0] tt, input int n);
    logic [15:0] s;
    s = 16'h0;
    for (int i = 0; i < n; i++) begin
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^ {15'h0, tt[i]};
    end
    return s;
  endfunction

  function automatic logic [15:0] model_bits(input logic [15:0] tt, input int n);
    int unsigned m;
    m = (32'd1 << n) - 1;
    return tt & m[15:0];
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    n_checks++; if ({busy, done, resp_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, done, resp_valid}); end
    n_checks++; if (n_val !== 4'h0) begin n_fail++; $display("FAIL reset_N got %h want 0", n_val); end
    n_checks++; if (resp_index !== 4'h0 || resp_bits !== 16'h0) begin n_fail++; $display("FAIL reset_resp got idx %h bits %h want 0 0", resp_index, resp_bits); end
    n_checks++; if (signature !== 16'h0) begin n_fail++; $display("FAIL reset_sig got %h want 0000", signature); end
    repeat (5) tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || n_val !== 4'h0) begin n_fail++; $display("FAIL idle_hold got busy %b done %b N %h want 0 0 0", busy, done, n_val); end
  endtask

  // Full sweep with cycle-by-cycle timing checks; optionally pokes start
  // while busy at pattern 3, which must have no effect.
  task automatic do_sweep(input logic [15:0] tt, input bit poke_busy, input string name);
    int exp_n;
    bit exp_v;
    truth = tt;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (resp_bits !== 16'h0 || signature !== 16'h0 || done !== 1'b0) begin
      n_fail++; $display("FAIL %s_start_clear got bits %h sig %h done %b want 0 0 0", name, resp_bits, signature, done);
    end
    for (int c = 0; c <= SWEEP; c++) begin
      exp_n = (c / PER > NPAT - 1) ? NPAT - 1 : c / PER;
      exp_v = (c > 0) && (c % PER == 0);
      n_checks++; if (n_val !== exp_n[NW-1:0]) begin n_fail++; $display("FAIL %s_N c=%0d got %h want %h", name, c, n_val, exp_n[NW-1:0]); end
      n_checks++; if (busy !== (c < SWEEP) || done !== (c >= SWEEP)) begin n_fail++; $display("FAIL %s_busy_done c=%0d got %b%b want %b%b", name, c, busy, done, c < SWEEP, c >= SWEEP); end
      n_checks++; if (resp_valid !== exp_v) begin n_fail++; $display("FAIL %s_valid c=%0d got %b want %b", name, c, resp_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (resp_index !== 4'(c / PER - 1)) begin n_fail++; $display("FAIL %s_index c=%0d got %h want %h", name, c, resp_index, 4'(c / PER - 1)); end
      end
      if (c < SWEEP) begin
        start = (poke_busy && c == 3 * PER) ? 1'b1 : 1'b0;
        tick();
        start = 1'b0;
      end
    end
    n_checks++; if (resp_bits !== tt) begin n_fail++; $display("FAIL %s_bits got %h want %h", name, resp_bits, tt); end
    n_checks++; if (signature !== model_sig(tt, NPAT)) begin n_fail++; $display("FAIL %s_sig got %h want %h", name, signature, model_sig(tt, NPAT)); end
    repeat (3) tick();
    n_checks++; if (done !== 1'b1 || resp_bits !== tt || signature !== model_sig(tt, NPAT) || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_frozen got done %b bits %h sig %h valid %b", name, done, resp_bits, signature, resp_valid);
    end
  endtask

  task automatic test_default_sweep();
    do_sweep(16'hFFFF, 1'b0, "ones");
  endtask

  task automatic test_misr();
    do_sweep(16'h0001, 1'b0, "misr");
    n_checks++; if (signature !== 16'h8000 || resp_bits !== 16'h0001) begin n_fail++; $display("FAIL misr_literal got sig %h bits %h want 8000 0001", signature, resp_bits); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      do_sweep(16'($urandom), 1'b0, "rand");
    end
  endtask

  task automatic test_abort();
    logic [15:0] tt;
    int waited;
    tt = 16'($urandom) | 16'h0015;
    truth = tt;
    start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (n_val !== 4'h5 && waited < 40) begin tick(); waited++; end
    n_checks++; if (n_val !== 4'h5) begin n_fail++; $display("FAIL abort_reach got N %h want 5", n_val); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || n_val !== 4'h0) begin n_fail++; $display("FAIL abort_state got busy %b done %b N %h want 0 0 0", busy, done, n_val); end
    for (int c = 0; c < 8; c++) begin
      n_checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_quiet c=%0d got valid %b busy %b want 0 0", c, resp_valid, busy); end
      tick();
    end
    n_checks++; if (resp_bits !== model_bits(tt, 5)) begin n_fail++; $display("FAIL abort_partial_bits got %h want %h", resp_bits, model_bits(tt, 5)); end
    n_checks++; if (signature !== model_sig(tt, 5)) begin n_fail++; $display("FAIL abort_partial_sig got %h want %h", signature, model_sig(tt, 5)); end
    do_sweep(16'($urandom), 1'b0, "post_abort");
  endtask

  task automatic test_protocol_corners();
    logic [15:0] prev_bits, prev_sig;
    do_sweep(16'($urandom), 1'b1, "busy_start");
    do_sweep(16'($urandom), 1'b0, "done_restart");
    prev_bits = resp_bits;
    prev_sig  = signature;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || n_val !== 4'h0) begin n_fail++; $display("FAIL start_abort got busy %b done %b N %h want 0 0 0", busy, done, n_val); end
    n_checks++; if (resp_bits !== prev_bits || signature !== prev_sig) begin n_fail++; $display("FAIL start_abort_hold got %h/%h want %h/%h", resp_bits, signature, prev_bits, prev_sig); end
  endtask

  task automatic test_async_reset();
    int waited;
    truth = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (n_val !== 4'hA && waited < 40) begin tick(); waited++; end
    n_checks++; if (n_val !== 4'hA) begin n_fail++; $display("FAIL areset_reach got N %h want a", n_val); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if ({busy, done, resp_valid} !== 3'b000 || n_val !== 4'h0) begin n_fail++; $display("FAIL areset_ctrl got flags %b N %h want 000 0", {busy, done, resp_valid}, n_val); end
    n_checks++; if (resp_bits !== 16'h0 || signature !== 16'h0 || resp_index !== 4'h0) begin n_fail++; $display("FAIL areset_data got bits %h sig %h idx %h want 0", resp_bits, signature, resp_index); end
    tick();
    reset = 1'b1;
    repeat (4) tick();
    n_checks++; if (busy !== 1'b0 || n_val !== 4'h0) begin n_fail++; $display("FAIL areset_noresume got busy %b N %h want 0 0", busy, n_val); end
  endtask

  initial begin
    test_reset();
    test_default_sweep();
    test_misr();
    test_random();
    test_abort();
    test_protocol_corners();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
